// File: rtl/mul4x4_seq_sched_if.sv
// Operand/product handshake bundle for mul4x4_seq_sched.
// slave = the multiplier, master = the producer/consumer driving it.
interface mul4x4_seq_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       busy;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_p, busy
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_p, busy
  );
endinterface

// File: rtl/mul4x4_seq_sched.sv
// 4x4 unsigned multiplier that reuses one 2x2 partial-product unit over four steps.
// Define MUL4X4_SEQ_EXACT_EN for an exact 2x2 unit; default is approximate (3x3 -> 7).
module mul4x4_seq_sched (
  input  logic                 clk,
  input  logic                 rst_n,
  mul4x4_seq_sched_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q,  step_d;
  logic [7:0]  acc_q,   acc_d;
  logic [3:0]  a_q,     a_d;
  logic [3:0]  b_q,     b_d;

  logic        accept;
  logic [1:0]  pp_x, pp_y;
  logic [2:0]  pp_sh;
  logic [3:0]  pp_exact;
  logic [3:0]  pp;
  logic [7:0]  pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    accept  = bus.in_valid && (state_q == IDLE);
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)            state_d = CALC;
      CALC:    if (step_q == 2'd3)    state_d = DONE;
      DONE:    if (bus.out_ready)     state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.busy      = (state_q != IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_p     = acc_q;
  end

  // Step order: lo*lo, hi*lo, lo*hi, hi*hi with weights 1, 4, 4, 16.
  always_comb begin
    pp_x  = a_q[1:0];
    pp_y  = b_q[1:0];
    pp_sh = 3'd0;
    case (step_q)
      2'd0: begin pp_x = a_q[1:0]; pp_y = b_q[1:0]; pp_sh = 3'd0; end
      2'd1: begin pp_x = a_q[3:2]; pp_y = b_q[1:0]; pp_sh = 3'd2; end
      2'd2: begin pp_x = a_q[1:0]; pp_y = b_q[3:2]; pp_sh = 3'd2; end
      default: begin pp_x = a_q[3:2]; pp_y = b_q[3:2]; pp_sh = 3'd4; end
    endcase
  end

  always_comb begin
    pp_exact = {2'b00, pp_x} * {2'b00, pp_y};
`ifdef MUL4X4_SEQ_EXACT_EN
    pp = pp_exact;
`else
    // 3x3 is the only product needing a fourth bit; saturate it to 3'b111.
    pp = ((pp_x == 2'd3) && (pp_y == 2'd3)) ? 4'd7 : pp_exact;
`endif
    pp_shifted = {4'b0000, pp} << pp_sh;
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    step_d = step_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d    = bus.in_a;
          b_d    = bus.in_b;
          acc_d  = 8'd0;
          step_d = 2'd0;
        end
      end
      CALC: begin
        acc_d  = acc_q + pp_shifted;
        step_d = step_q + 2'd1;
      end
      default: begin
        acc_d  = acc_q;
        step_d = step_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      acc_q  <= 8'd0;
      step_q <= 2'd0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

endmodule

// File: tb/tb_mul4x4_seq_sched.sv
// Directed self-checking bench for mul4x4_seq_sched (both builds via MUL4X4_SEQ_EXACT_EN).
module tb_mul4x4_seq_sched;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;

`ifdef MUL4X4_SEQ_EXACT_EN
  localparam logic [7:0] EXP_3X3   = 8'd9;
  localparam logic [7:0] EXP_15X15 = 8'd225;
  localparam logic [7:0] EXP_15X15_AFTER_E2 = 8'd45;
`else
  localparam logic [7:0] EXP_3X3   = 8'd7;
  localparam logic [7:0] EXP_15X15 = 8'd175;
  localparam logic [7:0] EXP_15X15_AFTER_E2 = 8'd35;
`endif

  mul4x4_seq_sched_if bus ();

  mul4x4_seq_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Offer a pair at a negedge, let it be accepted, then count edges until out_valid.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        output int edges, output logic [7:0] p);
    edges = -1;
    p     = 8'hxx;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        edges = n;
        p     = bus.out_p;
        break;
      end
    end
  endtask

  task automatic finish_out();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    compared++;
    if (bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    compared++;
    if (bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
    end
    compared++;
    if (bus.out_p !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_out_p got=%0d want=0", bus.out_p);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int edges;
    logic [7:0] p;
    run_op(4'd6, 4'd5, edges, p);
    compared++;
    if (edges !== 4) begin
      mismatched++;
      $display("[TB] FAIL basic_latency got=%0d want=4", edges);
    end
    compared++;
    if (p !== 8'd30) begin
      mismatched++;
      $display("[TB] FAIL basic_6x5 got=%0d want=30", p);
    end
    finish_out();
  endtask

  task automatic test_approx();
    int edges;
    logic [7:0] p;
    run_op(4'd3, 4'd3, edges, p);
    compared++;
    if (p !== EXP_3X3) begin
      mismatched++;
      $display("[TB] FAIL pp_3x3 got=%0d want=%0d", p, EXP_3X3);
    end
    finish_out();
    run_op(4'd15, 4'd15, edges, p);
    compared++;
    if (p !== EXP_15X15) begin
      mismatched++;
      $display("[TB] FAIL pp_15x15 got=%0d want=%0d", p, EXP_15X15);
    end
    finish_out();
    compared++;
    if (bus.out_p !== EXP_15X15 || bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL idle_hold got=%0d/%b want=%0d/1", bus.out_p, bus.in_ready, EXP_15X15);
    end
  endtask

  task automatic test_backpressure();
    int edges;
    logic [7:0] p;
    run_op(4'd10, 4'd13, edges, p);
    compared++;
    if (p !== 8'd130) begin
      mismatched++;
      $display("[TB] FAIL bp_10x13 got=%0d want=130", p);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b1 || bus.out_p !== 8'd130 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL bp_hold_%0d got v=%b p=%0d r=%b b=%b want v=1 p=130 r=0 b=1",
                 i, bus.out_valid, bus.out_p, bus.in_ready, bus.busy);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    compared++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_p !== 8'd130) begin
      mismatched++;
      $display("[TB] FAIL bp_release got r=%b v=%b p=%0d want r=1 v=0 p=130",
               bus.in_ready, bus.out_valid, bus.out_p);
    end
  endtask

  task automatic test_ignore_busy();
    int edges;
    logic [7:0] p;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd6;
    bus.in_b     = 4'd5;
    @(posedge clk);
    #1;
    bus.in_a = 4'd9;
    bus.in_b = 4'd9;
    edges = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        edges = n;
        break;
      end
    end
    compared++;
    if (edges < 0 || bus.out_p !== 8'd30) begin
      mismatched++;
      $display("[TB] FAIL busy_ignore got=%0d want=30", bus.out_p);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    compared++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL no_accept_on_handshake got r=%b b=%b want r=1 b=0", bus.in_ready, bus.busy);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    edges = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) begin
        edges = n;
        break;
      end
    end
    compared++;
    if (edges !== 4 || bus.out_p !== 8'd81) begin
      mismatched++;
      $display("[TB] FAIL late_9x9 got=%0d after %0d edges want=81 after 4", bus.out_p, edges);
    end
    finish_out();
    p = 8'd0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 4'd15;
    bus.in_b     = 4'd15;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (bus.out_p !== EXP_15X15_AFTER_E2) begin
      mismatched++;
      $display("[TB] FAIL partial_acc got=%0d want=%0d", bus.out_p, EXP_15X15_AFTER_E2);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (bus.out_p !== 8'd0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL async_clear got p=%0d b=%b v=%b want 0/0/0", bus.out_p, bus.busy, bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL post_reset_%0d got v=%b r=%b want v=0 r=1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_back_to_back();
    int hit_edge [2];
    logic [7:0] hit_p [2];
    int hits;
    hits = 0;
    hit_edge[0] = -1;
    hit_edge[1] = -1;
    hit_p[0] = 8'hff;
    hit_p[1] = 8'hff;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'd0;
    bus.in_b      = 4'd15;
    @(posedge clk);
    #1;
    bus.in_a = 4'd15;
    bus.in_b = 4'd0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid && hits < 2) begin
        hit_edge[hits] = n;
        hit_p[hits]    = bus.out_p;
        hits++;
      end
      if (n == 6) bus.in_valid = 1'b0;
    end
    bus.out_ready = 1'b0;
    compared++;
    if (hit_edge[0] !== 4 || hit_p[0] !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_first got edge=%0d p=%0d want edge=4 p=0", hit_edge[0], hit_p[0]);
    end
    compared++;
    if (hit_edge[1] - hit_edge[0] !== 6 || hit_p[1] !== 8'd0) begin
      mismatched++;
      $display("[TB] FAIL b2b_second got gap=%0d p=%0d want gap=6 p=0",
               hit_edge[1] - hit_edge[0], hit_p[1]);
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 4'd0;
    bus.in_b      = 4'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_approx();
    test_backpressure();
    test_ignore_busy();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
